// File: rtl/mips_trace_buffer.sv
// Circular {PC, instruction, ALU} trace capture for the MIPS core with programmable
// trigger and post-trigger depth; frozen trace is popped oldest-first with 1-cycle latency.
module mips_trace_buffer #(
   parameter  int DATA_W = 32,
   parameter  int DEPTH  = 16,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cap_en,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [DATA_W-1:0] instr_in,
   input  logic [DATA_W-1:0] alu_in,
   input  logic              jump_in,
   input  logic              arm,
   input  logic [1:0]        trig_mode,
   input  logic [DATA_W-1:0] trig_value,
   input  logic [AW-1:0]     post_count,
   input  logic              rd_en,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_pc,
   output logic [DATA_W-1:0] rd_instr,
   output logic [DATA_W-1:0] rd_alu,
   output logic [AW:0]       level,
   output logic              armed,
   output logic              triggered,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] instr;
      logic [DATA_W-1:0] alu;
   } samp_t;

   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   state_t         state_q, state_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]    level_q, level_d;
   logic [AW-1:0]  rem_q, rem_d;
   logic           rd_valid_q;
   samp_t          rd_q;
   samp_t          mem_q [DEPTH];

   logic           trig_hit;
   logic           wr_en;
   logic           rd_fire;
   logic [AW-1:0]  rd_idx;

   always_comb begin
      trig_hit = 1'b0;
      unique case (trig_mode)
         2'b00: trig_hit = 1'b0;
         2'b01: trig_hit = jump_in;
         2'b10: trig_hit = (pc_in == trig_value);
         2'b11: trig_hit = (instr_in == trig_value);
      endcase
   end

   // With a full buffer level[AW-1:0] is 0, so the oldest entry is wr_ptr itself.
   assign rd_idx = wr_ptr_q - level_q[AW-1:0];

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      rem_d    = rem_q;
      wr_en    = 1'b0;
      rd_fire  = 1'b0;
      if (arm) begin
         state_d  = ARMED;
         wr_ptr_d = '0;
         level_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: ;
            ARMED: if (cap_en) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               level_d  = (level_q == LVL_FULL) ? level_q : level_q + 1'b1;
               if (trig_hit) begin
                  if (post_count == '0) begin
                     state_d = DONE;
                  end else begin
                     rem_d   = post_count;
                     state_d = POST;
                  end
               end
            end
            POST: if (cap_en) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               level_d  = (level_q == LVL_FULL) ? level_q : level_q + 1'b1;
               rem_d    = rem_q - 1'b1;
               if (rem_q == AW'(1)) state_d = DONE;
            end
            DONE: if (rd_en && level_q != '0) begin
               rd_fire = 1'b1;
               level_d = level_q - 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         level_q    <= '0;
         rem_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_q       <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         level_q    <= level_d;
         rem_q      <= rem_d;
         rd_valid_q <= rd_fire;
         if (rd_fire) rd_q <= mem_q[rd_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem_q[wr_ptr_q] <= {pc_in, instr_in, alu_in};
   end

   assign rd_valid  = rd_valid_q;
   assign rd_pc     = rd_q.pc;
   assign rd_instr  = rd_q.instr;
   assign rd_alu    = rd_q.alu;
   assign level     = level_q;
   assign armed     = (state_q == ARMED);
   assign triggered = (state_q == POST) || (state_q == DONE);
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Scoreboard bench: a queue-based model predicts each read beat; a negedge monitor checks them.
module tb_mips_trace_buffer;
   localparam int DW = 32, DEPTH = 16, AW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1, cap_en = 1'b0, jump_in = 1'b0, arm = 1'b0, rd_en = 1'b0;
   logic [DW-1:0] pc_in = '0, instr_in = '0, alu_in = '0, trig_value = '0;
   logic [1:0]    trig_mode = 2'b00;
   logic [AW-1:0] post_count = '0;
   logic          rd_valid, armed, triggered, done;
   logic [DW-1:0] rd_pc, rd_instr, rd_alu;
   logic [AW:0]   level;

   mips_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .cap_en(cap_en), .pc_in(pc_in), .instr_in(instr_in),
      .alu_in(alu_in), .jump_in(jump_in), .arm(arm), .trig_mode(trig_mode),
      .trig_value(trig_value), .post_count(post_count), .rd_en(rd_en),
      .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_alu(rd_alu),
      .level(level), .armed(armed), .triggered(triggered), .done(done)
   );

   typedef struct {
      logic [DW-1:0] pc;
      logic [DW-1:0] instr;
      logic [DW-1:0] alu;
   } samp_t;

   // Model: 0 idle, 1 armed, 2 post-trigger, 3 done; buffer is a plain queue of samples.
   samp_t         m_buf[$];
   samp_t         exp_q[$];
   logic [DW-1:0] got_pc[$];
   int            m_st = 0, m_rem = 0;
   bit            m_rdv = 0, mon_on = 0;
   int            n_chk = 0, n_pass = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   function automatic bit trig_cond();
      case (trig_mode)
         2'b01:   return jump_in;
         2'b10:   return pc_in == trig_value;
         2'b11:   return instr_in == trig_value;
         default: return 1'b0;
      endcase
   endfunction

   task automatic record();
      samp_t s;
      s.pc = pc_in; s.instr = instr_in; s.alu = alu_in;
      m_buf.push_back(s);
      if (m_buf.size() > DEPTH) m_buf.delete(0);
   endtask

   task automatic model_edge();
      if (rst) begin
         m_st = 0; m_rem = 0; m_rdv = 0;
         m_buf.delete();
      end else begin
         m_rdv = 0;
         if (arm) begin
            m_buf.delete();
            m_st = 1;
         end else begin
            case (m_st)
               1: if (cap_en) begin
                  record();
                  if (trig_cond()) begin
                     if (post_count == 0) m_st = 3;
                     else begin m_rem = post_count; m_st = 2; end
                  end
               end
               2: if (cap_en) begin
                  record();
                  m_rem--;
                  if (m_rem == 0) m_st = 3;
               end
               3: if (rd_en && m_buf.size() > 0) begin
                  exp_q.push_back(m_buf.pop_front());
                  m_rdv = 1;
               end
               default: ;
            endcase
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   always @(negedge clk) begin : monitor
      samp_t s;
      if (mon_on) begin
         chk("level", 64'(level), 64'(m_buf.size()));
         chk("armed", 64'(armed), 64'(m_st == 1));
         chk("triggered", 64'(triggered), 64'(m_st >= 2));
         chk("done", 64'(done), 64'(m_st == 3));
         chk("rd_valid", 64'(rd_valid), 64'(m_rdv));
         if (rd_valid) begin
            if (exp_q.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
            else begin
               s = exp_q.pop_front();
               chk("rd_pc", 64'(rd_pc), 64'(s.pc));
               chk("rd_instr", 64'(rd_instr), 64'(s.instr));
               chk("rd_alu", 64'(rd_alu), 64'(s.alu));
            end
            got_pc.push_back(rd_pc);
         end
      end
   end

   task automatic do_arm();
      arm = 1; step(); arm = 0;
   endtask

   task automatic read_all(int n);
      got_pc.delete();
      rd_en = 1; repeat (n) step();
      rd_en = 0; step(); step();
   endtask

   initial begin
      // Reset state
      rst = 1; step(); step();
      mon_on = 1;
      rst = 0; step();
      chk("rst_rd_pc", 64'(rd_pc), 64'd0);
      chk("rst_rd_alu", 64'(rd_alu), 64'd0);
      chk("rst_level", 64'(level), 64'd0);

      // PC trigger at 0x40, three post samples, buffer wraps
      do_arm();
      trig_mode = 2'b10; trig_value = 32'h40; post_count = 3;
      for (int i = 0; i < 20; i++) begin
         cap_en = 1; pc_in = 32'(i * 4); instr_in = $urandom; alu_in = $urandom;
         step();
         if (i == 18) chk("A_not_done_early", 64'(done), 64'd0);
      end
      for (int i = 20; i < 24; i++) begin
         pc_in = 32'(i * 4); step();
      end
      cap_en = 0;
      chk("A_done", 64'(done), 64'd1);
      chk("A_level", 64'(level), 64'd16);
      read_all(16);
      chk("A_nreads", 64'(got_pc.size()), 64'd16);
      for (int i = 0; i < got_pc.size(); i++)
         chk("A_order", 64'(got_pc[i]), 64'(32'h10 + 4 * i));

      // Early trigger at 0x08, two post samples; one extra rd_en
      do_arm();
      trig_value = 32'h08; post_count = 2;
      for (int i = 0; i < 8; i++) begin
         cap_en = 1; pc_in = 32'(i * 4); instr_in = $urandom; alu_in = $urandom;
         step();
      end
      cap_en = 0;
      chk("B_level", 64'(level), 64'd5);
      read_all(6);
      chk("B_nreads", 64'(got_pc.size()), 64'd5);
      if (got_pc.size() == 5) chk("B_last", 64'(got_pc[4]), 64'h10);

      // Jump trigger requires cap_en
      do_arm();
      trig_mode = 2'b01; post_count = 0;
      for (int i = 0; i < 3; i++) begin
         cap_en = 1; jump_in = 0; pc_in = 32'(i * 4); step();
      end
      cap_en = 0; jump_in = 1; pc_in = 32'h500; step();
      chk("C_no_trig", 64'(triggered), 64'd0);
      cap_en = 1; jump_in = 1; pc_in = 32'h777; step();
      cap_en = 0; jump_in = 0;
      chk("C_done", 64'(done), 64'd1);
      read_all(5);
      if (got_pc.size() > 0) chk("C_last_is_jump", 64'(got_pc[got_pc.size()-1]), 64'h777);
      else chk("C_nreads", 64'd0, 64'd4);

      // Instruction trigger with qualified samples only
      do_arm();
      trig_mode = 2'b11; trig_value = 32'hCAFE0001; post_count = 3;
      for (int i = 0; i < 30; i++) begin
         cap_en = (i % 2 == 0); pc_in = 32'(i * 4); alu_in = $urandom;
         instr_in = (i == 5 || i == 10) ? trig_value : ($urandom | 32'h1_0000_000);
         step();
      end
      cap_en = 0;
      chk("D_level", 64'(level), 64'd9);
      read_all(10);
      chk("D_nreads", 64'(got_pc.size()), 64'd9);
      if (got_pc.size() == 9) chk("D_last", 64'(got_pc[8]), 64'h40);

      // Reset mid-POST with five entries
      do_arm();
      trig_mode = 2'b10; trig_value = 32'h10; post_count = 8;
      for (int i = 0; i < 5; i++) begin
         cap_en = 1; pc_in = 32'(i * 4); step();
      end
      chk("F_triggered", 64'(triggered), 64'd1);
      chk("F_level5", 64'(level), 64'd5);
      rst = 1; step(); rst = 0; cap_en = 0;
      chk("F_rst_level", 64'(level), 64'd0);
      chk("F_rst_flags", 64'({armed, triggered, done, rd_valid}), 64'd0);
      chk("F_rst_rd_pc", 64'(rd_pc), 64'd0);

      // arm beats rd_en in DONE, then mode 00 saturates
      do_arm();
      trig_mode = 2'b01; post_count = 0; cap_en = 1; jump_in = 1; step();
      cap_en = 0; jump_in = 0;
      chk("E_done", 64'(done), 64'd1);
      arm = 1; rd_en = 1; step(); arm = 0; rd_en = 0;
      chk("E_armed", 64'(armed), 64'd1);
      chk("E_level0", 64'(level), 64'd0);
      trig_mode = 2'b00;
      for (int i = 0; i < 40; i++) begin
         cap_en = 1; jump_in = $urandom_range(0, 1); pc_in = $urandom; instr_in = $urandom;
         step();
      end
      cap_en = 0;
      chk("E_never_done", 64'(done), 64'd0);
      chk("E_saturate", 64'(level), 64'd16);

      // Random mix
      trig_value = 32'h4;
      for (int i = 0; i < 500; i++) begin
         rst = ($urandom_range(0, 149) == 0);
         arm = ($urandom_range(0, 24) == 0);
         cap_en = ($urandom_range(0, 3) != 0);
         pc_in = 32'($urandom_range(0, 15) * 4);
         instr_in = 32'($urandom_range(0, 7));
         alu_in = $urandom;
         jump_in = ($urandom_range(0, 7) == 0);
         trig_mode = 2'($urandom_range(0, 3));
         post_count = AW'($urandom_range(0, DEPTH - 1));
         rd_en = $urandom_range(0, 1);
         step();
      end
      rst = 0; arm = 0; cap_en = 0; rd_en = 0;
      step(); step(); step();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
